riscv_mc_controller: RTL and testbench
======================================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of cycles a memory request waits for mem_ready before a fault.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rstN, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port opcode, input, 7, opCode_t taken from the instruction register.
REQ-005 SHALL have port branch_taken, input, 1, comparator result for the current B-type instruction.
REQ-006 SHALL have port mem_ready, input, 1, memory completion strobe.
REQ-007 SHALL have port mem_req, output, 1, memory request.
REQ-008 SHALL have port mem_we, output, 1, write enable qualifying mem_req.
REQ-009 SHALL have port mem_addr_sel, output, 1, memory address source: 1 = PC, 0 = ALU result.
REQ-010 SHALL have port ir_write, pc_write, reg_write, each output, 1, register load strobes; pc_write always loads the ALU result.
REQ-011 SHALL have port alu_op, output, 2, aluOp_t.
REQ-012 SHALL have port alu_src_a, output, 2, alu_sel_t: ZERO = rs1, ONE = PC, TWO = constant 0, THREE = old_pc.
REQ-013 SHALL have port alu_src_b, output, 2, alu_sel_t: ZERO = rs2, ONE = imm, TWO = constant 4.
REQ-014 SHALL have port wb_sel, output, 2, alu_sel_t: ZERO = ALU result, ONE = memory data, TWO = PC.
REQ-015 SHALL have port retire, output, 1, one-cycle pulse on instruction completion.
REQ-016 SHALL have port fault, output, 2, fault code: 0 = none, 1 = illegal opcode, 2 = memory timeout.
REQ-017 SHALL have port state, output, 3, encoding FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

Function
REQ-018 SHALL be a Moore/Mealy FSM. Defaults in every state: all strobes 0, alu_op DEF_ADD, all selects ZERO.
REQ-019 FETCH SHALL:
- assert mem_req with mem_addr_sel=1, alu_src_a=ONE, alu_src_b=TWO;
- on the mem_ready cycle, assert ir_write and pc_write (PC+4) and go to DECODE;
- otherwise hold.
REQ-020 DECODE SHALL take one cycle with no strobes. A legal opcode goes to EXECUTE; any other opcode goes to TRAP with fault=1.
REQ-021 EXECUTE SHALL set outputs and the next state by opcode:
- RTYPE: rs1/rs2, TYPE_R, then WB.
- ITYPE: rs1/imm, TYPE_I, then WB.
- LTYPE/STYPE: rs1/imm, DEF_ADD, then MEM.
- LUI: zero/imm, then WB.
- AUIPC: old_pc/imm, then WB.
- JTYPE: old_pc/imm, pc_write=1, then WB.
- JALR: rs1/imm, pc_write=1, then WB.
- BTYPE: old_pc/imm, pc_write=branch_taken, retire=1, then FETCH.
REQ-022 MEM SHALL:
- assert mem_req with mem_addr_sel=0, and mem_we=1 for STYPE only;
- hold until mem_ready;
- on mem_ready, a store asserts retire and goes to FETCH; a load goes to WB.
REQ-023 WB SHALL assert reg_write and retire, then go to FETCH. wb_sel is ONE for LTYPE, TWO for JTYPE/JALR, and ZERO otherwise.
REQ-024 mem_ready SHALL complete a request in the same cycle it is first seen, including the first cycle of the request. mem_ready outside FETCH/MEM SHALL be ignored.
REQ-025 While mem_req is high, mem_we and mem_addr_sel SHALL be stable.
REQ-026 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without mem_ready. When the count reaches MEM_TIMEOUT, the FSM goes to TRAP with fault=2. The counter saturates and never wraps.
REQ-027 TRAP SHALL assert no strobes. TRAP and fault are sticky until reset.
REQ-028 Minimum latency, FETCH entry to retire (zero-wait memory):
- BTYPE: 3 cycles;
- store: 4 cycles;
- R/I/LUI/AUIPC/JAL/JALR: 4 cycles;
- load: 5 cycles.

Reset
REQ-029 While rstN=0 at a clock edge: state becomes FETCH, counter 0, fault 0, and all outputs are driven inactive (strobes 0, selects ZERO).
REQ-030 A reset mid-request SHALL abandon the transaction. The first cycle after rstN=1 SHALL be FETCH with mem_req=1.

Verification
REQ-031 Reset release, ADD (0110011), mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 and retire=1 in cycle 4; alu_op=TYPE_R in EXECUTE.
REQ-032 LW (0000011), mem_ready delayed 3 cycles in MEM -> mem_req=1 and mem_we=0 for 4 cycles; then WB with wb_sel=ONE; retire in cycle 8.
REQ-033 BEQ (1100011) with branch_taken=0, then with 1 -> pc_write=0, then 1, in EXECUTE; retire in EXECUTE; no WB state visited.
REQ-034 opcode=7'b1111111 -> TRAP after DECODE, fault=1; TRAP held for 20 cycles despite mem_ready toggling.
REQ-035 mem_ready held 0 in FETCH -> TRAP with fault=2 exactly at MEM_TIMEOUT=16 cycles; rstN=0 for one edge -> FETCH, fault=0.
REQ-036 rstN=0 during a SW MEM wait -> next cycle all strobes 0; after release, FETCH with mem_addr_sel=1.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch, decode, execute, memory and
// write-back, with a memory wait timeout and a sticky trap state.
module riscv_mc_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic [1:0] fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_R   = 2'd1;
    localparam logic [1:0] ALU_I   = 2'd2;

    localparam logic [1:0] SEL_ZERO  = 2'd0;
    localparam logic [1:0] SEL_ONE   = 2'd1;
    localparam logic [1:0] SEL_TWO   = 2'd2;
    localparam logic [1:0] SEL_THREE = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    fault_q;
    logic [1:0]    fault_d;
    logic          timeout_hit;
    logic          op_legal;

    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_L, OP_S, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    // The last waiting cycle without mem_ready is the one that times out.
    assign timeout_hit = (wait_cnt >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cur_state <= S_FETCH;
            fault_q   <= FAULT_NONE;
        end else begin
            cur_state <= nxt_state;
            fault_q   <= fault_d;
        end
    end

    // Cleared on every state change, so entry to FETCH/MEM starts from zero.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wait_cnt <= '0;
        end else if (nxt_state != cur_state) begin
            wait_cnt <= '0;
        end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !mem_ready
                     && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Outputs are forced inactive whenever rstN is low, whatever the state.
    always_comb begin
        nxt_state    = cur_state;
        fault_d      = fault_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_a    = SEL_ZERO;
        alu_src_b    = SEL_ZERO;
        wb_sel       = SEL_ZERO;
        retire       = 1'b0;
        if (rstN) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    alu_src_a    = SEL_ONE;
                    alu_src_b    = SEL_TWO;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        nxt_state = S_DECODE;
                    end else if (timeout_hit) begin
                        nxt_state = S_TRAP;
                        fault_d   = FAULT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    if (op_legal) begin
                        nxt_state = S_EXECUTE;
                    end else begin
                        nxt_state = S_TRAP;
                        fault_d   = FAULT_ILLEGAL;
                    end
                end
                S_EXECUTE: begin
                    alu_src_b = SEL_ONE;
                    nxt_state = S_WB;
                    case (opcode)
                        OP_R: begin
                            alu_src_b = SEL_ZERO;
                            alu_op    = ALU_R;
                        end
                        OP_I:       alu_op    = ALU_I;
                        OP_L, OP_S: nxt_state = S_MEM;
                        OP_LUI:     alu_src_a = SEL_TWO;
                        OP_AUIPC:   alu_src_a = SEL_THREE;
                        OP_JAL: begin
                            alu_src_a = SEL_THREE;
                            pc_write  = 1'b1;
                        end
                        OP_JALR:    pc_write  = 1'b1;
                        OP_B: begin
                            alu_src_a = SEL_THREE;
                            pc_write  = branch_taken;
                            retire    = 1'b1;
                            nxt_state = S_FETCH;
                        end
                        default: begin
                            nxt_state = S_TRAP;
                            fault_d   = FAULT_ILLEGAL;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (opcode == OP_S);
                    if (mem_ready) begin
                        if (opcode == OP_S) begin
                            retire    = 1'b1;
                            nxt_state = S_FETCH;
                        end else begin
                            nxt_state = S_WB;
                        end
                    end else if (timeout_hit) begin
                        nxt_state = S_TRAP;
                        fault_d   = FAULT_TIMEOUT;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                    case (opcode)
                        OP_L:             wb_sel = SEL_ONE;
                        OP_JAL, OP_JALR:  wb_sel = SEL_TWO;
                        default:          wb_sel = SEL_ZERO;
                    endcase
                end
                S_TRAP:  nxt_state = S_TRAP;
                default: nxt_state = S_TRAP;
            endcase
        end
    end

    assign fault = rstN ? fault_q : FAULT_NONE;
    assign state = cur_state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Cycle-by-cycle vector bench for riscv_mc_controller: each vector drives the
// inputs for one cycle and checks the full output bundle against a hand value.
module tb_riscv_mc_controller;

    localparam int TMO = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;

    logic       clk = 1'b0;
    logic       rstN;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, retire;
    logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel, fault;
    logic [2:0] state;

    riscv_mc_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rstN(rstN), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .wb_sel(wb_sel), .retire(retire), .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    // {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
    //  alu_op, alu_src_a, alu_src_b, wb_sel, retire, fault}
    typedef logic [19:0] obs_t;

    typedef struct {
        logic       rstn;
        logic [6:0] op;
        logic       bt;
        logic       rdy;
        obs_t       exp;
        string      name;
    } vec_t;

    vec_t tbl[$];
    obs_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic obs_t ev(logic [2:0] st, logic mreq, logic mwe, logic masel,
                                logic irw, logic pcw, logic rw, logic [1:0] aop,
                                logic [1:0] sa, logic [1:0] sb, logic [1:0] wb,
                                logic ret, logic [1:0] flt);
        return {st, mreq, mwe, masel, irw, pcw, rw, aop, sa, sb, wb, ret, flt};
    endfunction

    function automatic obs_t idle_e(logic [2:0] st, logic [1:0] flt);
        return ev(st, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, flt);
    endfunction
    function automatic obs_t fetch_e(logic rdy);
        return ev(ST_F, 1, 0, 1, rdy, rdy, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 2'd0);
    endfunction
    function automatic obs_t exec_e(logic [1:0] aop, logic [1:0] sa, logic [1:0] sb,
                                    logic pcw, logic ret);
        return ev(ST_E, 0, 0, 0, 0, pcw, 0, aop, sa, sb, 2'd0, ret, 2'd0);
    endfunction
    function automatic obs_t mem_e(logic we, logic ret);
        return ev(ST_M, 1, we, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, ret, 2'd0);
    endfunction
    function automatic obs_t wb_e(logic [1:0] wb);
        return ev(ST_W, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, wb, 1, 2'd0);
    endfunction

    function automatic void add(logic rstn, logic [6:0] op, logic bt, logic rdy,
                                obs_t exp, string name);
        vec_t v;
        v.rstn = rstn; v.op = op; v.bt = bt; v.rdy = rdy; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    // Fetch, decode, execute and (optionally) write-back with zero-wait memory.
    function automatic void add_instr(logic [6:0] op, logic bt, obs_t ex, logic has_wb,
                                      logic [1:0] wb, string name);
        add(1, op, bt, 1, fetch_e(1), {name, "_fetch"});
        add(1, op, bt, 1, idle_e(ST_D, 2'd0), {name, "_decode"});
        add(1, op, bt, 1, ex, {name, "_exec"});
        if (has_wb) add(1, op, bt, 1, wb_e(wb), {name, "_wb"});
    endfunction

    task automatic run_vec(input logic rstn_i, input logic [6:0] op, input logic bt,
                           input logic rdy, input obs_t exp, input string name);
        obs_t got, want;
        @(posedge clk);
        #1;
        rstN = rstn_i; opcode = op; branch_taken = bt; mem_ready = rdy;
        exp_q.push_back(exp);
        @(negedge clk);
        got = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
               alu_op, alu_src_a, alu_src_b, wb_sel, retire, fault};
        want = exp_q.pop_front();
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got state=%0d bundle=%h, required state=%0d bundle=%h",
                      name, got[19:17], got, want[19:17], want);
    endtask

    initial begin
        rstN = 1'b0; opcode = OP_R; branch_taken = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        add(0, OP_R, 0, 1, idle_e(ST_F, 2'd0), "reset_idle");
        add_instr(OP_R, 0, exec_e(2'd1, 2'd0, 2'd0, 0, 0), 1, 2'd0, "add");
        // Load with three wait cycles in MEM.
        add_instr(OP_L, 0, exec_e(2'd0, 2'd0, 2'd1, 0, 0), 0, 2'd0, "lw");
        for (int i = 0; i < 3; i++) add(1, OP_L, 0, 0, mem_e(0, 0), "lw_mem_wait");
        add(1, OP_L, 0, 1, mem_e(0, 0), "lw_mem_done");
        add(1, OP_L, 0, 1, wb_e(2'd1), "lw_wb");
        add_instr(OP_S, 0, exec_e(2'd0, 2'd0, 2'd1, 0, 0), 0, 2'd0, "sw");
        add(1, OP_S, 0, 1, mem_e(1, 1), "sw_mem");
        add_instr(OP_B, 0, exec_e(2'd0, 2'd3, 2'd1, 0, 1), 0, 2'd0, "beq_nt");
        add_instr(OP_B, 1, exec_e(2'd0, 2'd3, 2'd1, 1, 1), 0, 2'd0, "beq_t");
        add_instr(OP_JAL, 0, exec_e(2'd0, 2'd3, 2'd1, 1, 0), 1, 2'd2, "jal");
        add_instr(OP_JALR, 0, exec_e(2'd0, 2'd0, 2'd1, 1, 0), 1, 2'd2, "jalr");
        add_instr(OP_LUI, 0, exec_e(2'd0, 2'd2, 2'd1, 0, 0), 1, 2'd0, "lui");
        add_instr(OP_AUIPC, 0, exec_e(2'd0, 2'd3, 2'd1, 0, 0), 1, 2'd0, "auipc");
        add_instr(OP_I, 0, exec_e(2'd2, 2'd0, 2'd1, 0, 0), 1, 2'd0, "addi");
        // Ready arriving on the last allowed waiting cycle still completes.
        for (int i = 0; i < TMO - 1; i++) add(1, OP_L, 0, 0, fetch_e(0), "fetch_wait");
        add(1, OP_L, 0, 1, fetch_e(1), "fetch_last_ok");
        add(1, OP_L, 0, 1, idle_e(ST_D, 2'd0), "lw2_decode");
        add(1, OP_L, 0, 1, exec_e(2'd0, 2'd0, 2'd1, 0, 0), "lw2_exec");
        for (int i = 0; i < TMO - 1; i++) add(1, OP_L, 0, 0, mem_e(0, 0), "lw2_mem_wait");
        add(1, OP_L, 0, 1, mem_e(0, 0), "lw2_mem_last_ok");
        add(1, OP_L, 0, 1, wb_e(2'd1), "lw2_wb");
        // Store that never sees mem_ready times out in MEM.
        add_instr(OP_S, 0, exec_e(2'd0, 2'd0, 2'd1, 0, 0), 0, 2'd0, "sw_tmo");
        for (int i = 0; i < TMO; i++) add(1, OP_S, 0, 0, mem_e(1, 0), "sw_tmo_mem");
        add(1, OP_S, 0, 1, idle_e(ST_T, 2'd2), "sw_tmo_trap");
        add(1, OP_S, 0, 0, idle_e(ST_T, 2'd2), "sw_tmo_trap_hold");
        add(0, OP_S, 0, 0, idle_e(ST_T, 2'd0), "sw_tmo_rst_assert");
        add(0, OP_S, 0, 0, idle_e(ST_F, 2'd0), "sw_tmo_rst_fetch");

        foreach (tbl[i]) run_vec(tbl[i].rstn, tbl[i].op, tbl[i].bt, tbl[i].rdy,
                                 tbl[i].exp, tbl[i].name);

        // Reset in the middle of a store's MEM wait abandons it.
        run_vec(1, OP_S, 0, 1, fetch_e(1), "rmid_fetch");
        run_vec(1, OP_S, 0, 1, idle_e(ST_D, 2'd0), "rmid_decode");
        run_vec(1, OP_S, 0, 1, exec_e(2'd0, 2'd0, 2'd1, 0, 0), "rmid_exec");
        run_vec(1, OP_S, 0, 0, mem_e(1, 0), "rmid_mem_wait");
        run_vec(1, OP_S, 0, 0, mem_e(1, 0), "rmid_mem_wait2");
        run_vec(0, OP_S, 0, 1, idle_e(ST_M, 2'd0), "rmid_rst_outputs_off");
        run_vec(0, OP_S, 0, 1, idle_e(ST_F, 2'd0), "rmid_rst_fetch");
        run_vec(1, OP_S, 0, 0, fetch_e(0), "rmid_release_fetch");

        // Illegal opcode traps after DECODE and stays there.
        run_vec(1, OP_BAD, 0, 1, fetch_e(1), "ill_fetch");
        run_vec(1, OP_BAD, 0, 1, idle_e(ST_D, 2'd0), "ill_decode");
        for (int i = 0; i < 20; i++)
            run_vec(1, OP_BAD, 1'($urandom_range(0, 1)), 1'(i % 2),
                    idle_e(ST_T, 2'd1), "ill_trap_hold");
        run_vec(0, OP_R, 0, 0, idle_e(ST_T, 2'd0), "ill_rst_assert");
        run_vec(0, OP_R, 0, 0, idle_e(ST_F, 2'd0), "ill_rst_fetch");

        // FETCH timeout lands in TRAP exactly TMO cycles after entry.
        for (int i = 0; i < TMO; i++) run_vec(1, OP_R, 0, 0, fetch_e(0), "ftmo_wait");
        for (int i = 0; i < 3; i++)
            run_vec(1, OP_R, 0, 1'($urandom_range(0, 1)), idle_e(ST_T, 2'd2), "ftmo_trap");
        run_vec(0, OP_R, 0, 0, idle_e(ST_T, 2'd0), "ftmo_rst_assert");
        run_vec(0, OP_R, 0, 0, idle_e(ST_F, 2'd0), "ftmo_rst_fetch");
        run_vec(1, OP_R, 0, 0, fetch_e(0), "ftmo_release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
